// File: rtl/wb_pkg.sv
// Shared widths, types and helpers for the register-file write-back path.
package wb_pkg;

    localparam int REG_IDX_W     = 5;
    localparam int DATA_W        = 32;
    localparam int NUM_ARCH_REGS = 32;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_IDX_W-1:0]     reg_idx_t;
    typedef logic [DATA_W-1:0]        reg_data_t;
    typedef logic [NUM_ARCH_REGS-1:0] reg_mask_t;

    // One-hot mask selecting a single architectural register.
    function automatic reg_mask_t idx_to_mask(input reg_idx_t idx);
        return reg_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the
// granted requester whenever a grant is issued. Generic enough to share any port.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic [N-1:0] ReqValid,
    output logic [N-1:0] Grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [N-1:0]     upper_mask;
    logic [N-1:0]     upper_valid;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_any;

    // Requesters at or after the pointer get first pick before wrapping.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign upper_mask[gi] = (ptr_reg <= PTR_W'(gi));
        end
    endgenerate

    assign upper_valid = ReqValid & upper_mask;
    assign grant_any   = |ReqValid;

    // Lowest-index valid requester in the upper window, else lowest overall.
    always_comb begin
        grant_idx = '0;
        if (|upper_valid) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (upper_valid[i]) begin
                    grant_idx = PTR_W'(i);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (ReqValid[i]) begin
                    grant_idx = PTR_W'(i);
                end
            end
        end
    end

    // Expand the winning index into the one-hot grant vector.
    generate
        for (gi = 0; gi < N; gi++) begin : g_grant
            assign Grant[gi] = grant_any && (grant_idx == PTR_W'(gi));
        end
    endgenerate

    // Next pointer sits just past the winner, wrapping at N.
    always_comb begin
        ptr_next = ptr_reg;
        if (grant_any) begin
            if (grant_idx == PTR_W'(N - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_idx + PTR_W'(1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, plus a
// destination scoreboard flagging registers with an outstanding write.
module rf_wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic [NUM_REQ-1:0]           ReqValid,
    input  logic [REG_IDX_W*NUM_REQ-1:0] ReqReg,
    input  logic [DATA_W*NUM_REQ-1:0]    ReqData,
    output logic [NUM_REQ-1:0]           ReqReady,
    input  logic                         Reserve,
    input  logic [REG_IDX_W-1:0]         ReserveReg,
    output logic                         RegWrite,
    output logic [REG_IDX_W-1:0]         WriteReg,
    output logic [DATA_W-1:0]            WriteData,
    output logic [NUM_ARCH_REGS-1:0]     Busy,
    output logic                         Err
);

    reg_idx_t  req_reg_f  [NUM_REQ];
    reg_data_t req_data_f [NUM_REQ];

    reg_idx_t  sel_reg;
    reg_data_t sel_data;
    logic      transfer;

    logic      regwrite_reg,   regwrite_next;
    reg_idx_t  write_reg_reg,  write_reg_next;
    reg_data_t write_data_reg, write_data_next;
    reg_mask_t busy_reg,       busy_next;
    logic      err_reg,        err_next;

    reg_mask_t set_mask;
    reg_mask_t clr_mask;
    logic      reserve_conflict;
    logic      write_unclaimed;

    // The register file always accepts, so the grant depends only on requests.
    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .ReqValid (ReqValid),
        .Grant    (ReqReady)
    );

    // Unpack the flat requester buses into per-requester fields.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_reg_f[gi]  = ReqReg[REG_IDX_W*gi +: REG_IDX_W];
            assign req_data_f[gi] = ReqData[DATA_W*gi +: DATA_W];
        end
    endgenerate

    assign transfer = |(ReqValid & ReqReady);

    // AND-OR mux of the granted requester's destination and data.
    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ReqReady[i]) begin
                sel_reg  = sel_reg  | req_reg_f[i];
                sel_data = sel_data | req_data_f[i];
            end
        end
    end

    // Output stage: writes to the zero register are accepted but not strobed.
    always_comb begin
        regwrite_next   = 1'b0;
        write_reg_next  = write_reg_reg;
        write_data_next = write_data_reg;
        if (transfer && (sel_reg != ZERO_REG)) begin
            regwrite_next   = 1'b1;
            write_reg_next  = sel_reg;
            write_data_next = sel_data;
        end
    end

    // Scoreboard: a write retires at the edge the register file captures it;
    // a claim at that same edge re-arms the bit for the newer producer.
    assign set_mask  = (Reserve && (ReserveReg != ZERO_REG)) ? idx_to_mask(ReserveReg) : '0;
    assign clr_mask  = regwrite_reg ? idx_to_mask(write_reg_reg) : '0;
    assign busy_next = (busy_reg & ~clr_mask) | set_mask;

    // Protocol errors: double claim of a still-pending register, or a write
    // arriving for a register nobody claimed.
    assign reserve_conflict = |(set_mask & busy_reg & ~clr_mask);
    assign write_unclaimed  = transfer && (sel_reg != ZERO_REG) &&
                              !(|(idx_to_mask(sel_reg) & busy_reg));

    // Error flag is sticky until reset.
    always_comb begin
        err_next = err_reg | reserve_conflict | write_unclaimed;
    end

    // State registers; reset drops any in-flight write.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            regwrite_reg   <= 1'b0;
            write_reg_reg  <= '0;
            write_data_reg <= '0;
            busy_reg       <= '0;
            err_reg        <= 1'b0;
        end else begin
            regwrite_reg   <= regwrite_next;
            write_reg_reg  <= write_reg_next;
            write_data_reg <= write_data_next;
            busy_reg       <= busy_next;
            err_reg        <= err_next;
        end
    end

    assign RegWrite  = regwrite_reg;
    assign WriteReg  = write_reg_reg;
    assign WriteData = write_data_reg;
    assign Busy      = busy_reg;
    assign Err       = err_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the write-back rules.
module tb_rf_wb_arbiter;

    localparam int N = 3;

    logic           Clk = 1'b0;
    logic           Rst_n;
    logic [N-1:0]   ReqValid;
    logic [5*N-1:0] ReqReg;
    logic [32*N-1:0] ReqData;
    logic [N-1:0]   ReqReady;
    logic           Reserve;
    logic [4:0]     ReserveReg;
    logic           RegWrite;
    logic [4:0]     WriteReg;
    logic [31:0]    WriteData;
    logic [31:0]    Busy;
    logic           Err;

    rf_wb_arbiter #(.NUM_REQ(N)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .ReqValid   (ReqValid),
        .ReqReg     (ReqReg),
        .ReqData    (ReqData),
        .ReqReady   (ReqReady),
        .Reserve    (Reserve),
        .ReserveReg (ReserveReg),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .Busy       (Busy),
        .Err        (Err)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int passes = 0;

    // Reference model state.
    int          m_ptr;
    bit          m_busy [32];
    bit          m_err;
    bit          m_rw;
    int          m_wreg;
    logic [31:0] m_wdata;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    function automatic int model_grant();
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (ReqValid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_err   = 0;
        m_rw    = 0;
        m_wreg  = 0;
        m_wdata = '0;
        for (int r = 0; r < 32; r++) m_busy[r] = 0;
    endtask

    // Apply the write-back rules for one rising edge using pre-edge state.
    task automatic model_edge(input int g);
        int         clr;
        int         rr;
        int         wr;
        clr = m_rw ? m_wreg : -1;
        rr  = int'(ReserveReg);
        wr  = (g >= 0) ? int'(ReqReg[5*g +: 5]) : 0;
        if (Reserve && rr != 0 && m_busy[rr] && clr != rr) m_err = 1;
        if (g >= 0 && wr != 0 && !m_busy[wr]) m_err = 1;
        if (clr > 0) m_busy[clr] = 0;
        if (Reserve && rr != 0) m_busy[rr] = 1;
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            m_rw  = (wr != 0);
            if (wr != 0) begin
                m_wreg  = wr;
                m_wdata = ReqData[32*g +: 32];
            end
        end else begin
            m_rw = 0;
        end
    endtask

    // Inputs are set before calling (at the falling edge); returns at the next falling edge.
    task automatic step(input string tag);
        int g;
        int exp_ready;
        #1;
        g = model_grant();
        exp_ready = (g >= 0) ? (1 << g) : 0;
        check_val({tag, ":ready"}, 64'(ReqReady), 64'(exp_ready));
        @(posedge Clk);
        model_edge(g);
        #1;
        check_val({tag, ":regwrite"}, 64'(RegWrite), 64'(m_rw));
        check_val({tag, ":busy"}, 64'(Busy), 64'(model_busy_vec()));
        check_val({tag, ":err"}, 64'(Err), 64'(m_err));
        if (m_rw) begin
            check_val({tag, ":wreg"}, 64'(WriteReg), 64'(m_wreg));
            check_val({tag, ":wdata"}, 64'(WriteData), 64'(m_wdata));
        end
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        ReqValid   = '0;
        ReqReg     = '0;
        ReqData    = '0;
        Reserve    = 1'b0;
        ReserveReg = '0;
    endtask

    // Assert reset (asynchronously), check cleared outputs, release at a falling edge.
    task automatic do_reset(input string tag);
        Rst_n = 1'b0;
        model_reset();
        #1;
        check_val({tag, ":rst_regwrite"}, 64'(RegWrite), 64'(0));
        check_val({tag, ":rst_wreg"}, 64'(WriteReg), 64'(0));
        check_val({tag, ":rst_wdata"}, 64'(WriteData), 64'(0));
        check_val({tag, ":rst_busy"}, 64'(Busy), 64'(0));
        check_val({tag, ":rst_err"}, 64'(Err), 64'(0));
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
        ReqValid[i]        = 1'b1;
        ReqReg[5*i +: 5]   = r;
        ReqData[32*i +: 32] = d;
    endtask

    initial begin
        idle_inputs();
        Rst_n = 1'b1;
        @(negedge Clk);
        do_reset("init");

        // Round-robin with all requesters pending: grants 0,1,2,0,1,2.
        for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'(100 + i));
        for (int i = 0; i < 6; i++) begin
            #1;
            check_val("rr_seq", 64'(ReqReady), 64'(1 << (i % 3)));
            step("rr");
        end
        idle_inputs();
        step("rr_drain");
        do_reset("rr_end");

        // Reserve r8, requester 1 writes -5 one cycle later.
        Reserve = 1'b1; ReserveReg = 5'd8;
        step("res8");
        check_val("busy8_c1", 64'(Busy[8]), 64'(1));
        Reserve = 1'b0;
        set_req(1, 5'd8, -32'sd5);
        step("wr8");
        check_val("busy8_c2", 64'(Busy[8]), 64'(1));
        check_val("wdata_neg5", 64'(WriteData), 64'(32'hFFFF_FFFB));
        idle_inputs();
        step("wr8_commit");
        check_val("busy8_clr", 64'(Busy[8]), 64'(0));
        check_val("err_legal", 64'(Err), 64'(0));

        // Write to r0 is accepted but never strobed.
        set_req(0, 5'd0, 32'd7);
        #1;
        check_val("zero_ready", 64'(ReqReady[0]), 64'(1));
        step("wr0");
        check_val("zero_regwrite", 64'(RegWrite), 64'(0));
        idle_inputs();

        // Re-claim r9 on the edge its pending write commits.
        Reserve = 1'b1; ReserveReg = 5'd9;
        step("res9");
        Reserve = 1'b0;
        set_req(2, 5'd9, 32'h1234_5678);
        step("wr9");
        idle_inputs();
        Reserve = 1'b1; ReserveReg = 5'd9;
        step("res9_again");
        check_val("busy9_setwins", 64'(Busy[9]), 64'(1));
        check_val("err_setwins", 64'(Err), 64'(0));
        idle_inputs();

        // Double claim of r10 raises a sticky error.
        Reserve = 1'b1; ReserveReg = 5'd10;
        step("res10_a");
        step("res10_b");
        check_val("err_double", 64'(Err), 64'(1));
        idle_inputs();
        for (int i = 0; i < 3; i++) step("err_hold");
        check_val("err_sticky", 64'(Err), 64'(1));
        do_reset("err_rst");

        // Reset mid-cycle while a write is in flight and r8/r9 are busy.
        Reserve = 1'b1; ReserveReg = 5'd8;
        step("mid_res8");
        ReserveReg = 5'd9;
        step("mid_res9");
        Reserve = 1'b0;
        set_req(1, 5'd8, 32'hCAFE_0001);
        step("mid_wr8");
        idle_inputs();
        #2;
        check_val("mid_regwrite", 64'(RegWrite), 64'(1));
        check_val("mid_busy", 64'(Busy), 64'(32'h0000_0300));
        do_reset("mid");
        ReqValid = 3'b111;
        #1;
        check_val("mid_ptr0", 64'(ReqReady), 64'(3'b001));
        step("mid_after");
        idle_inputs();

        // Randomized traffic, reset between chunks so Err keeps its meaning.
        for (int c = 0; c < 4; c++) begin
            do_reset("rnd_rst");
            for (int t = 0; t < 40; t++) begin
                ReqValid = 3'($urandom_range(0, 7));
                for (int i = 0; i < N; i++) begin
                    ReqReg[5*i +: 5]    = 5'($urandom_range(0, 4));
                    ReqData[32*i +: 32] = $urandom;
                end
                Reserve    = ($urandom_range(0, 3) == 0);
                ReserveReg = 5'($urandom_range(0, 4));
                step("rnd");
            end
            idle_inputs();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and destination scoreboard for the 32 x 32-bit register file. Shares the register file's single write port (RegWrite/WriteReg/WriteData) among NUM_REQ producers (ALU, load unit, multi-cycle mul/div) using round-robin, with one registered stage between grant and the write strobe. Also tracks which architectural registers have an issued-but-uncommitted write, so issue logic can stall on RAW hazards.

## Interface
- NUM_REQ, 3, number of write-back requesters (2..8)
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- ReqValid  in  NUM_REQ  requester i has a write pending
- ReqReg  in  5*NUM_REQ  destination index, requester i at [5*i +: 5]
- ReqData  in  32*NUM_REQ  signed write data, requester i at [32*i +: 32]
- ReqReady  out  NUM_REQ  one-hot grant; transfer when ReqValid[i] & ReqReady[i]
- Reserve  in  1  issue stage claims a destination this cycle
- ReserveReg  in  5  destination being claimed
- RegWrite  out  1  write strobe to register file
- WriteReg  out  5  register file write index
- WriteData  out  32  signed register file write data
- Busy  out  32  Busy[r]=1: register r has an outstanding write
- Err  out  1  sticky protocol-error flag

## Operation
- Arbitration: round-robin pointer Ptr (0..NUM_REQ-1). Among requesters with ReqValid set, grant the first at or after Ptr, wrapping. At most one ReqReady bit high per cycle; ReqReady is all-zero when no ReqValid.
- ReqReady is combinational from ReqValid and Ptr; it never depends on downstream state (the register file always accepts).
- On a transfer from requester g: Ptr <= (g+1) mod NUM_REQ. No transfer: Ptr unchanged.
- Output stage: on transfer, register RegWrite=1, WriteReg=ReqReg[g], WriteData=ReqData[g]. No transfer: RegWrite=0; WriteReg/WriteData hold their previous values.
- Writes to index 0: transfer is accepted (ReqReady asserted) but RegWrite stays 0 — write discarded.
- Scoreboard: Busy[r] set on Reserve with ReserveReg=r (r!=0). Busy[r] cleared in the cycle after the RegWrite=1 cycle for r, i.e. at the same edge the register file captures the data.
- Simultaneous set and clear of the same r: set wins (newer producer), Busy[r] stays 1.
- Reserve of r=0: ignored; Busy[0] is always 0.
- Reserve of an r already Busy and not being cleared that edge: Err <= 1; Busy[r] stays 1.
- Transfer to a non-zero r with Busy[r]=0: Err <= 1; write still performed.
- Err clears only on reset.

## Timing
- Reset (async assert, sync release): RegWrite=0, WriteReg=0, WriteData=0, Busy=0, Ptr=0, Err=0. ReqReady follows ReqValid with Ptr=0.
- Latency: transfer at edge t -> RegWrite=1 during cycle t+1 -> register file updated and Busy[r] cleared at edge t+1.
- Throughput: one write per cycle sustained; back-to-back transfers from different requesters produce back-to-back RegWrite pulses.
- Reset mid-operation: in-flight registered write is dropped, all Busy bits cleared.
- Busy[r]=1 from the edge after Reserve until the edge completing the write; read-port consumers must treat the value as stale while Busy.

## Structure
- Shared package wb_pkg: REG_IDX_W=5, DATA_W=32, NUM_ARCH_REGS=32, ZERO_REG=5'd0.
- Sub-module rr_arbiter (parameter N): ReqValid in, Grant one-hot out, pointer update on transfer; reusable for memory-port sharing.
- Top: rr_arbiter + grant mux + output register + 32-bit scoreboard + Err logic.

## Test plan
- Reset, then ReqValid=3'b111 held for 6 cycles -> grants 0,1,2,0,1,2; RegWrite=1 on each following cycle with matching WriteReg/WriteData.
- Reserve r=8, then one cycle later requester 1 writes r=8, data=-5 -> Busy[8]=1 for exactly 2 cycles after Reserve, WriteData=32'hFFFFFFFB, Err=0.
- Requester 0 writes r=0, data=7 -> ReqReady[0]=1, RegWrite stays 0, Busy unchanged.
- Reserve r=9 at the same edge its pending write commits -> Busy[9]=1 afterwards, Err=0.
- Reserve r=10 twice without a write -> Err=1 and stays 1 until Rst_n low.
- Assert Rst_n=0 mid-cycle while RegWrite=1 and Busy=32'h0000_0300 -> all outputs zero immediately, Ptr=0 after release.
